grid_evt_fifo: RTL
==================

// Module: grid_evt_fifo
// PURPOSE
//   Downstream consumer of the 3-lane AND-grid pipeline output (out[2:0]).
//   - Per-lane rising-edge detection on the grid output vector.
//   - Each cycle with at least one rising edge pushes one event into a FWFT FIFO.
//   - Events are drained through a valid/ready port to the host/logging side.
// PARAMETERS
//   DEPTH  8   FIFO entries; power of 2, >=2
//   TS_W   13  timestamp field width; event word width EVT_W = TS_W+3
// PORTS
//   clk        in   1                 single clock, rising edge
//   rst_n      in   1                 asynchronous, active-low reset
//   grid_q     in   3                 grid output vector, sampled every clk
//   evt_ready  in   1                 consumer accepts head event
//   evt_valid  out  1                 FIFO non-empty; head event on evt_data
//   evt_data   out  TS_W+3            {tstamp[TS_W-1:0], rise_mask[2:0]}
//   fill       out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   ovf        out  1                 sticky: an event was dropped
//   ovf_clr    in   1                 synchronous clear of ovf
// BEHAVIOUR
//   Reset (rst_n=0, async):
//   - prev_q=3'b000, ts=0, FIFO empty.
//   - evt_valid=0, evt_data=0, fill=0, ovf=0.
//   Edge detect:
//   - rise = grid_q & ~prev_q; prev_q <= grid_q every cycle.
//   - Because prev_q resets to 0, lanes already high at the first post-reset
//     edge are reported as rising.
//   - Push request: |rise at a sampling edge.
//     Entry = {ts value at that edge, rise}; ts is the pre-increment value.
//   - Latency: the push occurs at edge N; evt_valid is high in the cycle after N.
//   Timestamp:
//   - Free-running ts increments by 1 each cycle and wraps 2^TS_W-1 -> 0.
//   FIFO:
//   - First-word fall-through: evt_data = head whenever evt_valid=1.
//   - evt_data holds its last value when empty. It is 0 after reset.
//   - Pop when evt_valid & evt_ready. evt_ready is ignored when empty.
//   - Push when request & (fill<DEPTH | pop).
//     When full, a simultaneous pop and push is accepted and fill stays at DEPTH.
//   - Full, no pop, and a request: the event is dropped and ovf<=1.
//     FIFO contents are unchanged.
//   - ovf_clr clears ovf. If ovf_clr and a drop occur in the same cycle, set wins.
//   - Read and write pointers wrap modulo DEPTH. fill is exact, with no off-by-one
//     at full or empty.
//   - Push and pop on an empty FIFO in the same cycle: no pop occurs, because
//     evt_valid=0. The push lands, and evt_valid=1 the next cycle.
//   - Reset mid-operation discards all queued events immediately.
// CONFIGURATION
//   GRID_EVT_TSTAMP_EN defined:
//   - ts counter is instantiated.
//   - evt_data[TS_W+2:3] carries the timestamp.
//   GRID_EVT_TSTAMP_EN undefined:
//   - No ts counter is built.
//   - evt_data[TS_W+2:3] is constant 0.
//   - Port widths are unchanged, and all other behaviour is identical.
// TESTING
//   Sequences below assume GRID_EVT_TSTAMP_EN, with timestamps counted from the
//   first post-reset edge (ts=0).
//   1. Reset release, grid_q=000 for 5 cycles, then 3'b101 at edge 5
//      -> one event {ts=5, mask=101}; evt_valid high next cycle.
//   2. grid_q 001->011->111 on consecutive edges, evt_ready=1
//      -> events with masks 001, 010, 100 and consecutive ts values.
//   3. evt_ready=0, DEPTH+1 distinct rising events
//      -> fill=DEPTH, ovf=1, and the first DEPTH events are drained in order.
//   4. Full, with push and pop in the same cycle
//      -> fill stays DEPTH, the new event lands at the tail, ovf stays 0.
//   5. ovf=1 and ovf_clr asserted with no drop -> ovf=0 next cycle.
//      Repeat with a simultaneous drop -> ovf stays 1.
//   6. rst_n pulsed low mid-stream with 3 events queued
//      -> evt_valid=0 and fill=0 immediately.
//      With the macro undefined, the ts field is always 0.

Source files
------------

// File: rtl/grid_evt_fifo.sv
// Rising-edge event capture for the 3-lane grid output, queued in a FWFT FIFO.
// Define GRID_EVT_TSTAMP_EN to build the timestamp counter; otherwise the ts field is 0.
module grid_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               grid_q,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [TS_W+2:0]          evt_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              EVT_W    = TS_W + 3;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     ONE_CNT  = (AW+1)'(1);

    logic [2:0]       grid_p1;
    logic [2:0]       rise_p0;
    logic             req_p0;
    logic [TS_W-1:0]  ts_p0;
    logic [EVT_W-1:0] entry_p0;

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      fill_q;
    logic [EVT_W-1:0] head_q;
    logic [EVT_W-1:0] head_nxt;
    logic             ovf_q;

    logic             vld_p1;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Stage p0: edge detect against the previous sample, build the event word
    assign rise_p0  = grid_q & ~grid_p1;
    assign req_p0   = |rise_p0;
    assign entry_p0 = {ts_p0, rise_p0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_p1 <= 3'b000;
        end else begin
            grid_p1 <= grid_q;
        end
    end

`ifdef GRID_EVT_TSTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_p0 <= '0;
        end else begin
            ts_p0 <= ts_p0 + 1'b1;
        end
    end
`else
    assign ts_p0 = '0;
`endif

    // Stage p1: FIFO storage and handshake
    assign vld_p1 = (fill_q != '0);
    assign full   = (fill_q == FULL_CNT);
    assign pop    = vld_p1 & evt_ready;
    assign push   = req_p0 & (~full | pop);
    assign drop   = req_p0 & full & ~pop;
    assign rd_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Registered head so evt_data keeps the last shown event once the FIFO empties
    always_comb begin
        head_nxt = head_q;
        if (pop) begin
            if (fill_q != ONE_CNT) begin
                head_nxt = mem[rd_nxt];
            end else if (push) begin
                head_nxt = entry_p0;
            end
        end else if (!vld_p1 && push) begin
            head_nxt = entry_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_nxt;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign evt_valid = vld_p1;
    assign evt_data  = head_q;
    assign fill      = fill_q;
    assign ovf       = ovf_q;

endmodule
